// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the keypad code lock.
package code_lock_pkg;

    typedef enum logic [1:0] {
        StEntry,
        StUnlocked,
        StProgram,
        StLockout
    } state_e;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/code_lock_if.sv
// Keypad-side and actuator-side signals of the code lock.
interface code_lock_if
    import code_lock_pkg::*;
#(
    parameter int unsigned DIGIT_W   = 4,
    parameter int unsigned MAX_TRIES = 3
);
    localparam int unsigned FAIL_W = cnt_width(MAX_TRIES);

    logic [DIGIT_W-1:0] key;
    logic               key_valid;
    logic               relock;
    logic               prog_req;
    logic               locked;
    logic               lockout;
    logic               prog_active;
    logic [FAIL_W-1:0]  fail_cnt;
    logic               entry_done;

    modport master (
        output key, key_valid, relock, prog_req,
        input  locked, lockout, prog_active, fail_cnt, entry_done
    );

    modport slave (
        input  key, key_valid, relock, prog_req,
        output locked, lockout, prog_active, fail_cnt, entry_done
    );
endinterface

// File: rtl/lockout_timer.sv
// One-shot down-counter: runs for exactly CYCLES clocks after start.
module lockout_timer
    import code_lock_pkg::*;
#(
    parameter int unsigned CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done
);
    localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            cnt_d = CntW'(CYCLES - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign busy = run_q;
    assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/code_lock.sv
// Keypad code lock: full-entry compare, failure counting, timed lockout and
// reprogramming of the stored code while unlocked.
module code_lock
    import code_lock_pkg::*;
#(
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned CODE_LEN       = 6,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 24'h335256,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    code_lock_if.slave  bus
);
    localparam int unsigned CodeW = CODE_LEN * DIGIT_W;
    localparam int unsigned IdxW  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned FailW = cnt_width(MAX_TRIES);

    state_e             state_q, state_d;
    logic [DIGIT_W-1:0] entry_q  [CODE_LEN];
    logic [DIGIT_W-1:0] entry_d  [CODE_LEN];
    logic [DIGIT_W-1:0] shadow_q [CODE_LEN];
    logic [DIGIT_W-1:0] shadow_d [CODE_LEN];
    logic [CodeW-1:0]   code_q, code_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [FailW-1:0]   fail_q, fail_d;
    logic               done_q, done_d;

    logic             timer_start, timer_busy, timer_done;
    logic             last_digit, match;
    logic [CodeW-1:0] cand, shadow_full;

    lockout_timer #(
        .CYCLES (LOCKOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .busy  (timer_busy),
        .done  (timer_done)
    );

    // Flatten buffers with the incoming key in the last slot, so the final
    // digit is evaluated on the same edge it is sampled.
    always_comb begin
        cand        = '0;
        shadow_full = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            cand[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W]        = entry_q[i];
            shadow_full[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = shadow_q[i];
        end
        cand[DIGIT_W-1:0]        = bus.key;
        shadow_full[DIGIT_W-1:0] = bus.key;
    end

    assign last_digit = (idx_q == IdxW'(CODE_LEN - 1));
    assign match      = (cand == code_q);

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        shadow_d    = shadow_q;
        code_d      = code_q;
        idx_d       = idx_q;
        fail_d      = fail_q;
        done_d      = 1'b0;
        timer_start = 1'b0;

        unique case (state_q)
            StEntry: begin
                if (bus.key_valid) begin
                    if (last_digit) begin
                        idx_d  = '0;
                        done_d = 1'b1;
                        if (match) begin
                            state_d = StUnlocked;
                            fail_d  = '0;
                        end else begin
                            fail_d = fail_q + FailW'(1);
                            if (fail_q == FailW'(MAX_TRIES - 1)) begin
                                state_d     = StLockout;
                                timer_start = 1'b1;
                            end
                        end
                    end else begin
                        entry_d[idx_q] = bus.key;
                        idx_d          = idx_q + IdxW'(1);
                    end
                end
            end
            StUnlocked: begin
                if (bus.relock) begin
                    state_d = StEntry;
                    idx_d   = '0;
                end else if (bus.prog_req) begin
                    state_d = StProgram;
                    idx_d   = '0;
                end
            end
            StProgram: begin
                if (bus.relock) begin
                    state_d = StEntry;
                    idx_d   = '0;
                    for (int i = 0; i < CODE_LEN; i++) shadow_d[i] = '0;
                end else if (bus.key_valid) begin
                    if (last_digit) begin
                        code_d  = shadow_full;
                        state_d = StUnlocked;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        shadow_d[idx_q] = bus.key;
                        idx_d           = idx_q + IdxW'(1);
                    end
                end
            end
            StLockout: begin
                if (timer_done) begin
                    state_d = StEntry;
                    fail_d  = '0;
                    idx_d   = '0;
                end
            end
            default: state_d = StEntry;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEntry;
            code_q  <= DEFAULT_CODE;
            idx_q   <= '0;
            fail_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < CODE_LEN; i++) begin
                entry_q[i]  <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            fail_q   <= fail_d;
            done_q   <= done_d;
            entry_q  <= entry_d;
            shadow_q <= shadow_d;
        end
    end

    // The timer runs exactly while the FSM sits in lockout.
    assign bus.locked      = (state_q != StUnlocked) && (state_q != StProgram);
    assign bus.lockout     = timer_busy;
    assign bus.prog_active = (state_q == StProgram);
    assign bus.fail_cnt    = fail_q;
    assign bus.entry_done  = done_q;

endmodule

// File: tb/tb_code_lock.sv
// Self-checking bench for code_lock: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_code_lock;
    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned CODE_LEN = 6;
    localparam int unsigned TRIES    = 3;
    localparam int unsigned LCYC     = 1000;
    localparam logic [23:0] DEF_CODE = 24'h335256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    code_lock_if #(.DIGIT_W(DIGIT_W), .MAX_TRIES(TRIES)) bus ();

    code_lock #(
        .DIGIT_W        (DIGIT_W),
        .CODE_LEN       (CODE_LEN),
        .DEFAULT_CODE   (DEF_CODE),
        .MAX_TRIES      (TRIES),
        .LOCKOUT_CYCLES (LCYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain flags, digit queues and a countdown.
    int m_entry[$];
    int m_shadow[$];
    int m_code[CODE_LEN];
    bit m_open, m_prog, m_done;
    int m_lock_left, m_fails;

    function automatic void model_step(int k, bit kv, bit rl, bit pr, bit rs);
        bit eq;
        m_done = 0;
        if (rs) begin
            m_entry.delete(); m_shadow.delete();
            for (int i = 0; i < CODE_LEN; i++) begin
                logic [23:0] d;
                d = DEF_CODE;
                m_code[i] = int'(d[(CODE_LEN-1-i)*4 +: 4]);
            end
            m_open = 0; m_prog = 0; m_lock_left = 0; m_fails = 0;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_fails = 0;
                m_entry.delete();
            end
        end else if (m_prog) begin
            if (rl) begin
                m_prog = 0; m_open = 0; m_shadow.delete(); m_entry.delete();
            end else if (kv) begin
                m_shadow.push_back(k);
                if (m_shadow.size() == CODE_LEN) begin
                    for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_shadow[i];
                    m_shadow.delete();
                    m_prog = 0;
                    m_done = 1;
                end
            end
        end else if (m_open) begin
            if (rl) begin
                m_open = 0; m_entry.delete();
            end else if (pr) begin
                m_prog = 1; m_shadow.delete();
            end
        end else if (kv) begin
            m_entry.push_back(k);
            if (m_entry.size() == CODE_LEN) begin
                eq = 1;
                for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] != m_code[i]) eq = 0;
                m_done = 1;
                if (eq) begin
                    m_open = 1; m_fails = 0;
                end else begin
                    m_fails++;
                    if (m_fails == TRIES) m_lock_left = LCYC;
                end
                m_entry.delete();
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock: drive, step model at the edge, compare 1 time unit later.
    task automatic cycle(input int k, input bit kv, input bit rl, input bit pr, input bit rs);
        bus.key       = DIGIT_W'(k);
        bus.key_valid = kv;
        bus.relock    = rl;
        bus.prog_req  = pr;
        reset         = rs;
        @(posedge clk);
        model_step(k, kv, rl, pr, rs);
        #1;
        check("model_locked",   int'(bus.locked),      int'(!m_open));
        check("model_lockout",  int'(bus.lockout),     int'(m_lock_left > 0));
        check("model_prog",     int'(bus.prog_active), int'(m_prog));
        check("model_fail_cnt", int'(bus.fail_cnt),    m_fails);
        check("model_done",     int'(bus.entry_done),  int'(m_done));
    endtask

    task automatic enter(input logic [23:0] c);
        for (int i = 0; i < CODE_LEN; i++) cycle(int'(c[(CODE_LEN-1-i)*4 +: 4]), 1, 0, 0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_locked"},  int'(bus.locked),      1);
        check({tag, "_lockout"}, int'(bus.lockout),     0);
        check({tag, "_prog"},    int'(bus.prog_active), 0);
        check({tag, "_fail"},    int'(bus.fail_cnt),    0);
        check({tag, "_done"},    int'(bus.entry_done),  0);
    endtask

    typedef struct {
        int k; bit kv; bit rl; bit pr;
        bit e_locked; bit e_lockout; bit e_prog; int e_fail; bit e_done;
    } vec_t;
    vec_t tbl[30];

    initial begin
        int n, dones, k;
        bit kv, rl, pr, rs;

        tbl[0]  = '{3, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{3, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{5, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{2, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{5, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{6, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{7, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) tbl[9+i] = '{i + 1, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[14] = '{6, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[15] = '{9, 1, 1, 0, 1, 0, 0, 0, 0};
        tbl[16] = '{3, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[17] = '{3, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[18] = '{5, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[19] = '{2, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[20] = '{5, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[21] = '{6, 1, 0, 0, 1, 0, 0, 1, 1};
        for (int i = 0; i < 5; i++) tbl[22+i] = '{i + 1, 1, 0, 0, 1, 0, 0, 1, 0};
        tbl[27] = '{6, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[28] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
        tbl[29] = '{4, 1, 0, 1, 1, 0, 0, 0, 0};

        cycle(0, 0, 0, 0, 1);
        check_reset_values("reset");

        for (int i = 0; i < 30; i++) begin
            cycle(tbl[i].k, tbl[i].kv, tbl[i].rl, tbl[i].pr, 0);
            check($sformatf("tbl%0d_locked", i),  int'(bus.locked),      int'(tbl[i].e_locked));
            check($sformatf("tbl%0d_lockout", i), int'(bus.lockout),     int'(tbl[i].e_lockout));
            check($sformatf("tbl%0d_prog", i),    int'(bus.prog_active), int'(tbl[i].e_prog));
            check($sformatf("tbl%0d_fail", i),    int'(bus.fail_cnt),    tbl[i].e_fail);
            check($sformatf("tbl%0d_done", i),    int'(bus.entry_done),  int'(tbl[i].e_done));
        end

        // Two wrong entries: exactly two evaluations, no early reject.
        cycle(0, 0, 0, 0, 1);
        dones = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < CODE_LEN; i++) begin
                logic [23:0] w;
                w = 24'h335257;
                cycle(int'(w[(CODE_LEN-1-i)*4 +: 4]), 1, 0, 0, 0);
                dones += int'(bus.entry_done);
            end
        end
        check("wrong2_fail", int'(bus.fail_cnt), 2);
        check("wrong2_locked", int'(bus.locked), 1);
        check("wrong2_dones", dones, 2);

        // Third failure: lockout length, keys ignored, then unlock.
        enter(24'h111111);
        n = int'(bus.lockout);
        for (int i = 0; i < LCYC + 100; i++) begin
            cycle(3, 1, i % 7 == 0, i % 5 == 0, 0);
            if (bus.lockout) n++;
            else break;
        end
        check("lockout_len", n, LCYC);
        check("post_lockout_fail", int'(bus.fail_cnt), 0);
        enter(DEF_CODE);
        check("post_lockout_unlock", int'(bus.locked), 0);

        // Reset mid-entry.
        cycle(0, 0, 1, 0, 0);
        cycle(3, 1, 0, 0, 0);
        cycle(3, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check_reset_values("rst_entry");
        enter(DEF_CODE);
        check("rst_entry_unlock", int'(bus.locked), 0);

        // Reset after and during programming: code reverts to default.
        cycle(0, 0, 0, 1, 0);
        enter(24'h987654);
        cycle(0, 0, 0, 1, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check_reset_values("rst_prog");
        enter(DEF_CODE);
        check("rst_prog_revert", int'(bus.locked), 0);

        // Reset mid-lockout.
        cycle(0, 0, 1, 0, 0);
        for (int r = 0; r < 3; r++) enter(24'h000000);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);
        check("pre_rst_lockout", int'(bus.lockout), 1);
        cycle(0, 0, 0, 0, 1);
        check_reset_values("rst_lockout");
        enter(DEF_CODE);
        check("rst_lockout_unlock", int'(bus.locked), 0);

        // Randomized traffic, biased towards the right digits.
        for (int i = 0; i < 4000; i++) begin
            kv = ($urandom_range(0, 3) != 0);
            if (!m_open && !m_prog && $urandom_range(0, 3) != 0)
                k = m_code[m_entry.size()];
            else
                k = $urandom_range(0, 15);
            rl = ($urandom_range(0, 29) == 0);
            pr = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 999) == 0);
            cycle(k, kv, rl, pr, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
